// File: rtl/vga_controller.sv
// vga_controller: 640x480 @ 60 Hz VGA timing generator that renders a snake
// grid (16x16 pixel cells) from a per-frame snapshot of the segment and food
// coordinates.
//
// Ports:
//   Clock       system clock, all logic on its rising edge
//   ResetN      synchronous active-low reset
//   packSnakeY  segment rows, bit (h*YB+k) is bit k of segment h's row
//   packSnakeX  segment columns, bit (h*XB+k) is bit k of segment h's column
//   foodY/X     food cell row / column
//   RGB         RRRGGGBB colour, RGB[0] is the red MSB
//   HSync       horizontal sync, active low
//   VSync       vertical sync, active low
module vga_controller #(
  parameter int GRID_WIDTH  = 40,
  parameter int GRID_HEIGHT = 30,
  parameter int NUM_PIECES  = 16,
  parameter int PIX_DIV     = 4,
  localparam int XB = $clog2(GRID_WIDTH),
  localparam int YB = $clog2(GRID_HEIGHT)
) (
  input  logic                       Clock,
  input  logic                       ResetN,
  input  logic [0:NUM_PIECES*YB-1]   packSnakeY,
  input  logic [0:NUM_PIECES*XB-1]   packSnakeX,
  input  logic [YB-1:0]              foodY,
  input  logic [XB-1:0]              foodX,
  output logic [0:7]                 RGB,
  output logic                       HSync,
  output logic                       VSync
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [9:0] LAST_COL = 10'(GRID_WIDTH - 1);
  localparam logic [9:0] LAST_ROW = 10'(GRID_HEIGHT - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en;
  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  logic [NUM_PIECES-1:0][XB-1:0] seg_x_in, snap_x_q;
  logic [NUM_PIECES-1:0][YB-1:0] seg_y_in, snap_y_q;
  logic [XB-1:0]                 snap_fx_q;
  logic [YB-1:0]                 snap_fy_q;
  logic                          snap_en;

  logic [9:0] col, row;
  logic       visible, snake_hit, food_hit, border_hit;

  // Unpack the ascending-indexed input buses into per-segment fields.
  always_comb begin
    seg_x_in = '0;
    seg_y_in = '0;
    for (int h = 0; h < NUM_PIECES; h++) begin
      for (int k = 0; k < XB; k++) seg_x_in[h][k] = packSnakeX[h*XB+k];
      for (int k = 0; k < YB; k++) seg_y_in[h][k] = packSnakeY[h*YB+k];
    end
  end

  always_comb begin
    pix_en = (div_q == DW'(PIX_DIV - 1));
    div_d  = pix_en ? '0 : div_q + DW'(1);
    hc_d   = (hc_q == 10'd799) ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (hc_q == 10'd799) vc_d = (vc_q == 10'd524) ? 10'd0 : vc_q + 10'd1;
    // Latch at the start of vertical blanking so the whole next frame
    // renders from one consistent set of coordinates.
    snap_en = (hc_q == 10'd0) && (vc_q == 10'd480);
  end

  // Colour for the pixel currently addressed by hc_q/vc_q; registered below
  // together with the syncs so all three leave with the same latency.
  always_comb begin
    col        = {4'b0, hc_q[9:4]};
    row        = {4'b0, vc_q[9:4]};
    visible    = (hc_q < 10'd640) && (vc_q < 10'd480);
    snake_hit  = 1'b0;
    for (int h = 0; h < NUM_PIECES; h++) begin
      // A slot at (0,0) is an unused segment.
      if (((|snap_x_q[h]) || (|snap_y_q[h])) &&
          (10'(snap_x_q[h]) == col) && (10'(snap_y_q[h]) == row))
        snake_hit = 1'b1;
    end
    food_hit   = (10'(snap_fx_q) == col) && (10'(snap_fy_q) == row);
    border_hit = (col == 10'd0) || (row == 10'd0) ||
                 (col == LAST_COL) || (row == LAST_ROW);
    rgb_d = 8'b000_000_00;
    if (visible) begin
      if (snake_hit)       rgb_d = 8'b000_111_00;
      else if (food_hit)   rgb_d = 8'b111_000_00;
      else if (border_hit) rgb_d = 8'b111_111_11;
    end
    hs_d = !((hc_q >= 10'd656) && (hc_q <= 10'd751));
    vs_d = !((vc_q >= 10'd490) && (vc_q <= 10'd491));
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      div_q     <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      snap_x_q  <= '0;
      snap_y_q  <= '0;
      snap_fx_q <= '0;
      snap_fy_q <= '0;
    end else begin
      div_q <= div_d;
      if (pix_en) begin
        hc_q  <= hc_d;
        vc_q  <= vc_d;
        rgb_q <= rgb_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        if (snap_en) begin
          snap_x_q  <= seg_x_in;
          snap_y_q  <= seg_y_in;
          snap_fx_q <= foodX;
          snap_fy_q <= foodY;
        end
      end
    end
  end

  assign RGB   = rgb_q;
  assign HSync = hs_q;
  assign VSync = vs_q;

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: directed bench for vga_controller with default
// parameters. A reference pixel position is derived from the number of
// rising edges seen since reset release; outputs lag that position by one
// pixel period.
module tb_vga_controller;

  localparam int XB = 6;
  localparam int YB = 5;
  localparam int NP = 16;

  logic              Clock = 1'b0;
  logic              ResetN = 1'b0;
  logic [0:NP*YB-1]  packSnakeY = '0;
  logic [0:NP*XB-1]  packSnakeX = '0;
  logic [YB-1:0]     foodY = '0;
  logic [XB-1:0]     foodX = '0;
  logic [0:7]        RGB;
  logic              HSync, VSync;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int c = 0;            // rising edges with ResetN=1 since last reset
  int vs_fall0 = -1;    // cycle of the frame-0 VSync falling edge
  int ssx[NP], ssy[NP]; // snapshot the bench expects to be rendered
  int sfx, sfy;

  vga_controller dut (
    .Clock(Clock), .ResetN(ResetN),
    .packSnakeY(packSnakeY), .packSnakeX(packSnakeX),
    .foodY(foodY), .foodX(foodX),
    .RGB(RGB), .HSync(HSync), .VSync(VSync)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    if (ResetN) c++;
    else c = 0;
    #1;
  endtask

  task automatic set_seg(input int h, input int x, input int y);
    logic [XB-1:0] xv;
    logic [YB-1:0] yv;
    xv = x[XB-1:0];
    yv = y[YB-1:0];
    for (int k = 0; k < XB; k++) packSnakeX[h*XB+k] = xv[k];
    for (int k = 0; k < YB; k++) packSnakeY[h*YB+k] = yv[k];
  endtask

  task automatic clear_model();
    for (int h = 0; h < NP; h++) begin ssx[h] = 0; ssy[h] = 0; end
    sfx = 0; sfy = 0;
  endtask

  function automatic logic [7:0] model_rgb(input int x, input int y);
    if (x >= 640 || y >= 480) return 8'h00;
    for (int h = 0; h < NP; h++)
      if (!(ssx[h] == 0 && ssy[h] == 0) &&
          x >= ssx[h]*16 && x < ssx[h]*16 + 16 &&
          y >= ssy[h]*16 && y < ssy[h]*16 + 16)
        return 8'h1C;
    if (x >= sfx*16 && x < sfx*16 + 16 && y >= sfy*16 && y < sfy*16 + 16)
      return 8'hE0;
    if (x < 16 || x >= 624 || y < 16 || y >= 464) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic expect_now(output logic [7:0] er, output logic eh, output logic ev);
    int p, q, x, y;
    p = c / 4;
    if (p == 0) begin
      er = 8'h00; eh = 1'b1; ev = 1'b1;
    end else begin
      q = p - 1;
      x = q % 800;
      y = (q / 800) % 525;
      eh = !(x >= 656 && x <= 751);
      ev = !(y >= 490 && y <= 491);
      er = model_rgb(x, y);
    end
  endtask

  task automatic test_reset();
    clear_model();
    set_seg(0, 5, 5);
    foodX = 6'd10; foodY = 5'd5;
    ResetN = 1'b0;
    repeat (5) tick();
    chk_cnt++; if (RGB !== 8'h00) $display("FAIL reset_rgb: got %h want 00", RGB); else pass_cnt++;
    chk_cnt++; if (HSync !== 1'b1) $display("FAIL reset_hsync: got %b want 1", HSync); else pass_cnt++;
    chk_cnt++; if (VSync !== 1'b1) $display("FAIL reset_vsync: got %b want 1", VSync); else pass_cnt++;
  endtask

  // Frame 0: snapshot still cleared by reset even though inputs are set.
  task automatic test_frame_timing();
    int rgb_err = 0, sync_err = 0, hs_falls = 0, vs_falls = 0, hs_w_err = 0;
    int vs_low = 0, first_fall = -1, n_e0 = 0, n_1c = 0, hs_len = 0, bad_c = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, eh, ev;
    logic [7:0] er, bad_a = 0, bad_e = 0;
    clear_model();
    ResetN = 1'b1;
    while (c < 1680000) begin
      tick();
      expect_now(er, eh, ev);
      if (RGB !== er) begin
        if (rgb_err == 0) begin bad_a = RGB; bad_e = er; bad_c = c; end
        rgb_err++;
      end
      if (HSync !== eh || VSync !== ev) sync_err++;
      if (prev_hs && !HSync) begin hs_falls++; hs_len = 0; if (first_fall < 0) first_fall = c; end
      if (!HSync) hs_len++;
      if (!prev_hs && HSync && hs_len != 384) hs_w_err++;
      if (prev_vs && !VSync) begin vs_falls++; vs_fall0 = c; end
      if (!VSync) vs_low++;
      if (RGB === 8'hE0) n_e0++;
      if (RGB === 8'h1C) n_1c++;
      prev_hs = HSync; prev_vs = VSync;
    end
    chk_cnt++; if (rgb_err !== 0) $display("FAIL f0_rgb: %0d bad, first cycle %0d got %h want %h", rgb_err, bad_c, bad_a, bad_e); else pass_cnt++;
    chk_cnt++; if (sync_err !== 0) $display("FAIL f0_sync: %0d bad cycles, want 0", sync_err); else pass_cnt++;
    chk_cnt++; if (hs_falls !== 525) $display("FAIL f0_hs_pulses: got %0d want 525", hs_falls); else pass_cnt++;
    chk_cnt++; if (hs_w_err !== 0) $display("FAIL f0_hs_width: %0d pulses not 384 cycles", hs_w_err); else pass_cnt++;
    chk_cnt++; if (vs_falls !== 1) $display("FAIL f0_vs_pulses: got %0d want 1", vs_falls); else pass_cnt++;
    chk_cnt++; if (vs_low !== 6400) $display("FAIL f0_vs_low: got %0d want 6400", vs_low); else pass_cnt++;
    chk_cnt++; if (first_fall !== 2628) $display("FAIL f0_first_hs: got %0d want 2628", first_fall); else pass_cnt++;
    chk_cnt++; if (n_e0 !== 1024) $display("FAIL f0_food_corner: got %0d want 1024", n_e0); else pass_cnt++;
    chk_cnt++; if (n_1c !== 0) $display("FAIL f0_no_snake: got %0d want 0", n_1c); else pass_cnt++;
  endtask

  // Frame 1: renders (5,5)/(10,5); inputs change mid-frame without effect.
  task automatic test_render();
    int rgb_err = 0, n_e0 = 0, n_1c = 0, bad_c = 0, vs_fall1 = -1;
    logic prev_vs = 1'b1, eh, ev;
    logic [7:0] er, bad_a = 0, bad_e = 0;
    clear_model();
    ssx[0] = 5; ssy[0] = 5; sfx = 10; sfy = 5;
    while (c < 3360000) begin
      tick();
      if (c == 2000004) begin
        set_seg(0, 7, 3);
        set_seg(2, 0, 10);
        set_seg(15, 39, 1);
        foodX = 6'd7; foodY = 5'd3;
      end
      expect_now(er, eh, ev);
      if (RGB !== er) begin
        if (rgb_err == 0) begin bad_a = RGB; bad_e = er; bad_c = c; end
        rgb_err++;
      end
      if (RGB === 8'hE0) n_e0++;
      if (RGB === 8'h1C) n_1c++;
      if (prev_vs && !VSync && vs_fall1 < 0) vs_fall1 = c;
      prev_vs = VSync;
    end
    chk_cnt++; if (rgb_err !== 0) $display("FAIL f1_rgb: %0d bad, first cycle %0d got %h want %h", rgb_err, bad_c, bad_a, bad_e); else pass_cnt++;
    chk_cnt++; if (n_1c !== 1024) $display("FAIL f1_snake_cell: got %0d want 1024", n_1c); else pass_cnt++;
    chk_cnt++; if (n_e0 !== 1024) $display("FAIL f1_food_cell: got %0d want 1024", n_e0); else pass_cnt++;
    chk_cnt++; if (vs_fall1 - vs_fall0 !== 1680000) $display("FAIL frame_period: got %0d want 1680000", vs_fall1 - vs_fall0); else pass_cnt++;
  endtask

  // Frame 2 up to line 200: snake over food, snake over border.
  task automatic test_snake_priority();
    int rgb_err = 0, n_e0 = 0, n_1c = 0, bad_c = 0;
    logic eh, ev;
    logic [7:0] er, bad_a = 0, bad_e = 0;
    clear_model();
    ssx[0] = 7; ssy[0] = 3; ssx[2] = 0; ssy[2] = 10; ssx[15] = 39; ssy[15] = 1;
    sfx = 7; sfy = 3;
    while (c < 4000004) begin
      tick();
      expect_now(er, eh, ev);
      if (RGB !== er) begin
        if (rgb_err == 0) begin bad_a = RGB; bad_e = er; bad_c = c; end
        rgb_err++;
      end
      if (RGB === 8'hE0) n_e0++;
      if (RGB === 8'h1C) n_1c++;
    end
    chk_cnt++; if (rgb_err !== 0) $display("FAIL f2_rgb: %0d bad, first cycle %0d got %h want %h", rgb_err, bad_c, bad_a, bad_e); else pass_cnt++;
    chk_cnt++; if (n_1c !== 3072) $display("FAIL f2_snake_cells: got %0d want 3072", n_1c); else pass_cnt++;
    chk_cnt++; if (n_e0 !== 0) $display("FAIL f2_food_hidden: got %0d want 0", n_e0); else pass_cnt++;
  endtask

  // Reset at vc=200 for 3 cycles; timing and snapshot restart from zero.
  task automatic test_reset_midframe();
    int err = 0, first_fall = -1, bad_c = 0;
    logic prev_hs = 1'b1, eh, ev;
    logic [7:0] er;
    ResetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (RGB !== 8'h00) $display("FAIL midrst_rgb%0d: got %h want 00", i, RGB); else pass_cnt++;
      chk_cnt++; if (HSync !== 1'b1) $display("FAIL midrst_hs%0d: got %b want 1", i, HSync); else pass_cnt++;
      chk_cnt++; if (VSync !== 1'b1) $display("FAIL midrst_vs%0d: got %b want 1", i, VSync); else pass_cnt++;
    end
    clear_model();
    ResetN = 1'b1;
    while (c < 16000) begin
      tick();
      expect_now(er, eh, ev);
      if (RGB !== er || HSync !== eh || VSync !== ev) begin
        if (err == 0) bad_c = c;
        err++;
      end
      if (prev_hs && !HSync && first_fall < 0) first_fall = c;
      prev_hs = HSync;
    end
    chk_cnt++; if (err !== 0) $display("FAIL restart_outputs: %0d bad, first cycle %0d want 0 bad", err, bad_c); else pass_cnt++;
    chk_cnt++; if (first_fall !== 2628) $display("FAIL restart_first_hs: got %0d want 2628", first_fall); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_render();
    test_snake_priority();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 Parameter GRID_WIDTH, default 40: grid columns, each cell 16x16 pixels.
REQ-002 Parameter GRID_HEIGHT, default 30: grid rows, each cell 16x16 pixels.
REQ-003 Parameter NUM_PIECES, default 16: number of snake segment slots.
REQ-004 Parameter PIX_DIV, default 4: Clock cycles per pixel (100 MHz Clock gives a 25 MHz pixel rate).
REQ-005 Derived widths: XB = clog2(GRID_WIDTH), YB = clog2(GRID_HEIGHT).
REQ-006 Clock  in  1: single system clock; all logic on its rising edge.
REQ-007 ResetN  in  1: reset, synchronous and active-low.
REQ-008 packSnakeY  in  [0:NUM_PIECES*YB-1]: bit (h*YB+k) is bit k of segment h's row.
REQ-009 packSnakeX  in  [0:NUM_PIECES*XB-1]: bit (h*XB+k) is bit k of segment h's column.
REQ-010 foodY  in  YB: food row.
REQ-011 foodX  in  XB: food column.
REQ-012 RGB  out  [0:7]: colour as RRRGGGBB, with RGB[0] the red MSB.
REQ-013 HSync  out  1: horizontal sync, active low.
REQ-014 VSync  out  1: vertical sync, active low.

Function
REQ-015 An internal divider shall assert a one-Clock pixel enable every PIX_DIV cycles; counters and outputs shall change only on enable cycles.
REQ-016 Horizontal counter hc shall count 0..799 and wrap to 0.
- Visible: 0..639; front porch: 640..655; sync: 656..751; back porch: 752..799.
REQ-017 Vertical counter vc shall advance when hc wraps, count 0..524 and wrap to 0.
- Visible: 0..479; front porch: 480..489; sync: 490..491; back porch: 492..524.
REQ-018 HSync shall be 0 exactly while hc is in 656..751; VSync shall be 0 exactly while vc is in 490..491.
REQ-019 Cell mapping for a visible pixel: column = hc/16, row = vc/16.
REQ-020 Snapshot: all coordinate inputs shall be latched on the enable cycle where hc=0 and vc=480; rendering of the next frame shall use only the snapshot.
REQ-021 Inactive segment: a segment whose X and Y are both 0 shall be inactive and never drawn.
REQ-022 Colour priority for a visible pixel, highest first:
- snake cell (any active segment matches row and column): 8'b000_111_00;
- food cell: 8'b111_000_00;
- border cell (row 0, row GRID_HEIGHT-1, column 0 or column GRID_WIDTH-1): 8'b111_111_11;
- otherwise: 8'b000_000_00.
REQ-023 Food at (0,0) shall be drawn as food only if row/column 0 applies, which REQ-022 covers (food over border).
REQ-024 RGB shall be 0 whenever hc>=640 or vc>=480.
REQ-025 Latency: RGB, HSync and VSync shall be registered with equal latency of one pixel period relative to the counters, so colour and sync stay mutually aligned.
REQ-026 Segment matching shall be a parallel compare over all NUM_PIECES slots within one pixel period; no sequential search.

Reset
REQ-027 While ResetN=0 on a rising Clock, the following shall be cleared:
- divider, hc and vc: 0;
- RGB: 0; HSync: 1; VSync: 1;
- snapshot: all zero (all segments inactive, food at (0,0)).
REQ-028 On the first rising edge with ResetN=1, counting shall start from hc=0, vc=0.
REQ-029 Reset asserted mid-frame shall abort the frame immediately, with no partial-line completion.

Verification
REQ-030 Reset, then run 800*525*4 Clock cycles -> exactly 525 HSync low pulses each 96*4 cycles long, one VSync low pulse 2 lines long; period 1,680,000 cycles.
REQ-031 Segment 0 at (5,5), all other slots 0, food (10,5), one frame for the snapshot, then the next frame ->
- pixels x80..95, y80..95 are 8'h1C;
- pixels x160..175, y80..95 are 8'hE0;
- border pixels are 8'hFF;
- interior elsewhere is 8'h00.
REQ-032 Segment 0 and food both at (7,3) -> that cell renders 8'h1C (snake wins).
REQ-033 Change the inputs while vc<480 -> the current frame is unchanged; the change appears from the next frame.
REQ-034 Sample RGB during hc 640..799 or vc 480..524 -> always 8'h00.
REQ-035 Assert ResetN=0 at vc=200 for 3 cycles -> HSync=VSync=1 and RGB=0 during reset; after release the timing of REQ-030 restarts from hc=vc=0.
